branch_redirect_ctrl: RTL and testbench

Sequences misprediction recovery for the dual-issue pipeline. Each cycle it inspects both branches resolving in the M stage (slot 1 older than slot 2) and selects the oldest mispredict. It then issues a registered PC redirect plus flush pulses and blanks wrong-path resolutions for a fixed shadow window. It also drives predictor-update requests for every resolved branch.

---
 rtl/brc_pkg.sv | 8 +
 rtl/brc_mispred_detect.sv | 17 +
 rtl/branch_redirect_ctrl.sv | 135 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// brc_pkg: shared state encoding, default PC width and corrected-PC helper for branch_redirect_ctrl
package brc_pkg;
    localparam int BRC_PC_W = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_SHADOW} state_t;
    function automatic logic [BRC_PC_W-1:0] sel_correct_pc(input logic taken, input logic [BRC_PC_W-1:0] pcplus, input logic [BRC_PC_W-1:0] target);
        return taken ? target : pcplus;
    endfunction
endpackage

// File: rtl/brc_mispred_detect.sv
// brc_mispred_detect: per-slot mispredict flag and the address execution should have continued at
module brc_mispred_detect
    import brc_pkg::*;
#(
    parameter int PC_W = BRC_PC_W
) (
    input  logic            i_valid,
    input  logic            i_pred,
    input  logic            i_taken,
    input  logic [PC_W-1:0] i_pcplus,
    input  logic [PC_W-1:0] i_target,
    output logic            o_mis,
    output logic [PC_W-1:0] o_pc
);
    assign o_mis = i_valid & (i_pred != i_taken);
    assign o_pc  = sel_correct_pc(i_taken, i_pcplus, i_target);
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: oldest-mispredict selection, registered redirect/flush, wrong-path shadow and predictor updates; BRC_STATS_EN adds saturating statistics counters
module branch_redirect_ctrl
    import brc_pkg::*;
#(
    parameter int PC_W   = BRC_PC_W,
    parameter int SHADOW = 2
`ifdef BRC_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            br_valid1,
    input  logic            br_valid2,
    input  logic            pred1,
    input  logic            pred2,
    input  logic            taken1,
    input  logic            taken2,
    input  logic [PC_W-1:0] pcplus1,
    input  logic [PC_W-1:0] pcplus2,
    input  logic [PC_W-1:0] target1,
    input  logic [PC_W-1:0] target2,
    input  logic [PC_W-1:0] pc1,
    input  logic [PC_W-1:0] pc2,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush_front,
    output logic            kill_slot2,
    output logic            upd_valid1,
    output logic            upd_valid2,
    output logic [PC_W-1:0] upd_pc1,
    output logic [PC_W-1:0] upd_pc2,
    output logic            upd_taken1,
    output logic            upd_taken2,
    output logic            busy
`ifdef BRC_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
`endif
);
    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            w_mis1, w_mis2, w_eff1, w_eff2, w_win1, w_fire;
    logic [PC_W-1:0] w_cpc1, w_cpc2;

    brc_mispred_detect #(.PC_W(PC_W)) u_det1 (
        .i_valid(br_valid1), .i_pred(pred1), .i_taken(taken1),
        .i_pcplus(pcplus1), .i_target(target1), .o_mis(w_mis1), .o_pc(w_cpc1)
    );
    brc_mispred_detect #(.PC_W(PC_W)) u_det2 (
        .i_valid(br_valid2), .i_pred(pred2), .i_taken(taken2),
        .i_pcplus(pcplus2), .i_target(target2), .o_mis(w_mis2), .o_pc(w_cpc2)
    );

    // slot 2 is younger, so a slot-1 mispredict makes it wrong-path
    assign w_eff1 = br_valid1 & (r_state != ST_SHADOW) & ~hold;
    assign w_win1 = w_eff1 & w_mis1;
    assign w_eff2 = br_valid2 & (r_state != ST_SHADOW) & ~hold & ~w_win1;
    assign w_fire = (r_state == ST_IDLE) & (w_win1 | (w_eff2 & w_mis2));

    // redirect sequencer; REDIRECT always lasts exactly one cycle regardless of hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_front    <= 1'b0;
            kill_slot2     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_fire) begin
                    r_state        <= ST_REDIRECT;
                    redirect_valid <= 1'b1;
                    flush_front    <= 1'b1;
                    redirect_pc    <= w_win1 ? w_cpc1 : w_cpc2;
                    kill_slot2     <= w_win1 & br_valid2;
                    busy           <= 1'b1;
                end
                ST_REDIRECT: begin
                    r_state        <= ST_SHADOW;
                    r_cnt          <= 4'(SHADOW - 1);
                    redirect_valid <= 1'b0;
                    flush_front    <= 1'b0;
                    kill_slot2     <= 1'b0;
                end
                ST_SHADOW: if (!hold) begin
                    r_state <= (r_cnt == '0) ? ST_IDLE : ST_SHADOW;
                    busy    <= (r_cnt != '0);
                    r_cnt   <= (r_cnt == '0) ? r_cnt : r_cnt - 4'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // predictor update strobes for every branch that was not suppressed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid1 <= 1'b0;
            upd_valid2 <= 1'b0;
            upd_pc1    <= '0;
            upd_pc2    <= '0;
            upd_taken1 <= 1'b0;
            upd_taken2 <= 1'b0;
        end else begin
            upd_valid1 <= w_eff1;
            upd_valid2 <= w_eff2;
            upd_pc1    <= w_eff1 ? pc1 : upd_pc1;
            upd_pc2    <= w_eff2 ? pc2 : upd_pc2;
            upd_taken1 <= w_eff1 ? taken1 : upd_taken1;
            upd_taken2 <= w_eff2 ? taken2 : upd_taken2;
        end
    end

`ifdef BRC_STATS_EN
    logic [CNT_W:0] w_br_sum;
    assign w_br_sum = {1'b0, stat_branches} + (CNT_W+1)'(w_eff1) + (CNT_W+1)'(w_eff2);

    // saturating branch and redirect counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            stat_branches <= w_br_sum[CNT_W] ? '1 : w_br_sum[CNT_W-1:0];
            stat_mispred  <= (w_fire & ~&stat_mispred) ? stat_mispred + 1'b1 : stat_mispred;
        end
    end
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed vectors with a queued expected-response scoreboard
module tb_branch_redirect_ctrl;
    logic       clk = 0, rst = 0, hold = 0;
    logic       br_valid1 = 0, br_valid2 = 0, pred1 = 0, pred2 = 0, taken1 = 0, taken2 = 0;
    logic [7:0] pcplus1 = 8'h11, pcplus2 = 8'h13, target1 = 8'h40, target2 = 8'h50;
    logic [7:0] pc1 = 8'hA0, pc2 = 8'hA4;
    logic       redirect_valid, flush_front, kill_slot2, upd_valid1, upd_valid2, upd_taken1, upd_taken2, busy;
    logic [7:0] redirect_pc, upd_pc1, upd_pc2;
`ifdef BRC_STATS_EN
    logic [15:0] stat_branches, stat_mispred;
`endif
    int n_tests = 0, n_fail = 0;

    typedef struct {
        string      nm;
        logic       rv;
        logic [7:0] rpc;
        logic       ff, k2, u1, ut1;
        logic [7:0] upc1;
        logic       u2, ut2;
        logic [7:0] upc2;
        logic       bz;
    } exp_t;
    exp_t q[$];

    branch_redirect_ctrl #(.PC_W(8), .SHADOW(2)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .br_valid1(br_valid1), .br_valid2(br_valid2),
        .pred1(pred1), .pred2(pred2), .taken1(taken1), .taken2(taken2),
        .pcplus1(pcplus1), .pcplus2(pcplus2), .target1(target1), .target2(target2),
        .pc1(pc1), .pc2(pc2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_front(flush_front), .kill_slot2(kill_slot2),
        .upd_valid1(upd_valid1), .upd_valid2(upd_valid2),
        .upd_pc1(upd_pc1), .upd_pc2(upd_pc2),
        .upd_taken1(upd_taken1), .upd_taken2(upd_taken2),
        .busy(busy)
`ifdef BRC_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    // drive one M-stage sample and queue the response expected one cycle later
    task automatic step(input string nm, input logic h, v1, p1, t1, v2, p2, t2,
                        input logic rv, input logic [7:0] rpc, input logic ff, k2, u1, u2, bz);
        @(negedge clk);
        hold = h; br_valid1 = v1; pred1 = p1; taken1 = t1; br_valid2 = v2; pred2 = p2; taken2 = t2;
        q.push_back('{nm, rv, rpc, ff, k2, u1, t1, pc1, u2, t2, pc2, bz});
    endtask

    task automatic idle(input string nm, input logic bz);
        step(nm, 0, 0,0,0, 0,0,0, 0, 8'h00, 0, 0, 0, 0, bz);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d responses still pending, required 0", q.size());
            q.delete();
        end
    endtask

    // monitor: compare every registered response just after the edge that produced it
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_tests++;
                ok = redirect_valid == e.rv && flush_front == e.ff && kill_slot2 == e.k2 &&
                     upd_valid1 == e.u1 && upd_valid2 == e.u2 && busy == e.bz &&
                     (!e.rv || redirect_pc == e.rpc) &&
                     (!e.u1 || (upd_pc1 == e.upc1 && upd_taken1 == e.ut1)) &&
                     (!e.u2 || (upd_pc2 == e.upc2 && upd_taken2 == e.ut2));
                if (!ok) begin
                    n_fail++;
                    $display("FAIL %s: got rv=%b pc=%h ff=%b k2=%b u1=%b/%h/%b u2=%b/%h/%b busy=%b; required rv=%b pc=%h ff=%b k2=%b u1=%b/%h/%b u2=%b/%h/%b busy=%b",
                        e.nm, redirect_valid, redirect_pc, flush_front, kill_slot2, upd_valid1, upd_pc1, upd_taken1,
                        upd_valid2, upd_pc2, upd_taken2, busy, e.rv, e.rpc, e.ff, e.k2, e.u1, e.upc1, e.ut1,
                        e.u2, e.upc2, e.ut2, e.bz);
                end
            end
        end
    end

    task automatic chk_zero(input string nm);
        n_tests++;
        if ({redirect_valid, flush_front, kill_slot2, upd_valid1, upd_valid2, upd_taken1, upd_taken2, busy,
             redirect_pc, upd_pc1, upd_pc2} !== '0) begin
            n_fail++;
            $display("FAIL %s: got rv=%b ff=%b k2=%b u=%b%b busy=%b pc=%h upc=%h/%h, required all 0",
                nm, redirect_valid, flush_front, kill_slot2, upd_valid1, upd_valid2, busy, redirect_pc, upd_pc1, upd_pc2);
        end
    endtask

    initial begin
        #12 chk_zero("reset");
        @(negedge clk) rst = 1;
        // slot 1 taken-mispredict with slot 2 present: kill slot 2, 1+SHADOW busy cycles
        step("t1_mis", 0, 1,0,1, 1,0,0, 1, 8'h40, 1, 1, 1, 0, 1);
        idle("t1_redir", 1); idle("t1_sh1", 1); idle("t1_sh0", 0);
        // slot 2 not-taken mispredict behind a correct slot 1
        step("t2_mis", 0, 1,1,1, 1,1,0, 1, 8'h13, 1, 0, 1, 1, 1);
        idle("t2_redir", 1); idle("t2_sh1", 1); idle("t2_sh0", 0);
        // mispredicts inside the shadow are ignored, the first one after it redirects
        step("t3_mis", 0, 1,0,1, 0,0,0, 1, 8'h40, 1, 0, 1, 0, 1);
        idle("t3_redir", 1);
        step("t3_sh1", 0, 1,0,1, 0,0,0, 0, 8'h00, 0, 0, 0, 0, 1);
        step("t3_sh0", 0, 1,0,1, 0,0,0, 0, 8'h00, 0, 0, 0, 0, 0);
        step("t3_new", 0, 1,0,1, 0,0,0, 1, 8'h40, 1, 0, 1, 0, 1);
        idle("t3_redir2", 1); idle("t3_sh1b", 1); idle("t3_sh0b", 0);
        // hold for 3 cycles in the shadow stretches busy by 3
        step("t4_mis", 0, 1,1,0, 0,0,0, 1, 8'h11, 1, 0, 1, 0, 1);
        idle("t4_redir", 1);
        step("t4_hold_a", 1, 0,0,0, 0,0,0, 0, 8'h00, 0, 0, 0, 0, 1);
        step("t4_hold_b", 1, 0,0,0, 0,0,0, 0, 8'h00, 0, 0, 0, 0, 1);
        step("t4_hold_c", 1, 0,0,0, 0,0,0, 0, 8'h00, 0, 0, 0, 0, 1);
        idle("t4_sh1", 1); idle("t4_sh0", 0);
        // hold in IDLE defers a present mispredict until hold drops
        step("t4_hidle", 1, 1,0,1, 0,0,0, 0, 8'h00, 0, 0, 0, 0, 0);
        step("t4_release", 0, 1,0,1, 0,0,0, 1, 8'h40, 1, 0, 1, 0, 1);
        idle("t4_redir2", 1); idle("t4_sh1b", 1); idle("t4_sh0b", 0);
        // both correct and taken: updates only
        step("t5_ok", 0, 1,1,1, 1,1,1, 0, 8'h00, 0, 0, 1, 1, 0);
        // both mispredict: slot 1 wins, slot 2 gets no update
        step("t6_both", 0, 1,0,1, 1,0,1, 1, 8'h40, 1, 1, 1, 0, 1);
        idle("t6_redir", 1); idle("t6_sh1", 1); idle("t6_sh0", 0);
        // asynchronous reset while in the shadow
        step("t7_mis", 0, 1,0,1, 0,0,0, 1, 8'h40, 1, 0, 1, 0, 1);
        idle("t7_redir", 1);
        drain();
        #1 rst = 0;
        #1 chk_zero("reset_mid_shadow");
        @(negedge clk) rst = 1;
        // post-reset traffic: 5 effective branches, 2 redirects
        step("s_ok", 0, 1,1,1, 1,1,1, 0, 8'h00, 0, 0, 1, 1, 0);
        step("s_mis1", 0, 1,0,1, 1,1,1, 1, 8'h40, 1, 1, 1, 0, 1);
        idle("s_redir1", 1); idle("s_sh1a", 1); idle("s_sh0a", 0);
        step("s_mis2", 0, 1,1,1, 1,1,0, 1, 8'h13, 1, 0, 1, 1, 1);
        idle("s_redir2", 1); idle("s_sh1b", 1); idle("s_sh0b", 0);
        drain();
`ifdef BRC_STATS_EN
        n_tests++;
        if (stat_branches != 16'd5) begin
            n_fail++;
            $display("FAIL stat_branches: got %0d, required 5", stat_branches);
        end
        n_tests++;
        if (stat_mispred != 16'd2) begin
            n_fail++;
            $display("FAIL stat_mispred: got %0d, required 2", stat_mispred);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
